// File: rtl/byte_word_loader.sv
`default_nettype none
// ============================================================================
// Module      : byte_word_loader
// Description : Assembles a little-endian byte stream into WIDTH-bit words and
//               writes each completed word with a one-cycle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_word_loader #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_byte,
    output logic               in_ready,
    input  logic               abort,
    output logic [WIDTH-1:0]   wr_data,
    output logic               wr_enable,
    output logic               busy,
    output logic [COUNT_W-1:0] words_written
);

    localparam int c_NB    = WIDTH / 8;
    localparam int c_CNT_W = $clog2(c_NB);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_buf;
    logic [WIDTH-1:0]   w_buf_ins;
    logic [WIDTH-1:0]   r_wr_data;
    logic               r_wr_enable;
    logic [COUNT_W-1:0] r_words;
    logic               w_xfer;
    logic               w_last;

    assign in_ready      = reset && (r_state == S_IDLE || r_state == S_COLLECT);
    assign busy          = (r_state != S_IDLE);
    assign wr_data       = r_wr_data;
    assign wr_enable     = r_wr_enable;
    assign words_written = r_words;

    assign w_xfer = in_valid && in_ready;
    assign w_last = (r_cnt == c_CNT_W'(c_NB - 1));

    // Current buffer with the incoming byte merged into lane r_cnt.
    always_comb begin
        w_buf_ins = r_buf;
        for (int i = 0; i < c_NB; i++) begin
            if (r_cnt == c_CNT_W'(i)) begin
                w_buf_ins[8*i +: 8] = in_byte;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_xfer) begin
                    w_state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_xfer && w_last) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wr_enable <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wr_enable <= (w_state_next == S_WRITE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_buf     <= '0;
            r_wr_data <= '0;
            r_words   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_COLLECT: begin
                    if (abort) begin
                        r_cnt <= '0;
                        r_buf <= '0;
                    end else if (w_xfer) begin
                        r_buf <= w_buf_ins;
                        // In IDLE the index is zero, so w_last only fires in COLLECT.
                        if (w_last) begin
                            r_wr_data <= w_buf_ins;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    r_words <= r_words + COUNT_W'(1);
                    r_cnt   <= '0;
                    r_buf   <= '0;
                end
                default: begin
                    r_cnt <= '0;
                    r_buf <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_byte_word_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_word_loader
// Description : Directed self-checking bench for byte_word_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_byte_word_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        abort;
    logic [31:0] wr_data;
    logic        wr_enable;
    logic        busy;
    logic [7:0]  words_written;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    logic [31:0] wq[$];
    int          pq[$];

    always #5 clk = ~clk;

    byte_word_loader #(.WIDTH(32), .COUNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .in_ready     (in_ready),
        .abort        (abort),
        .wr_data      (wr_data),
        .wr_enable    (wr_enable),
        .busy         (busy),
        .words_written(words_written)
    );

    // Record every write strobe with its data and cycle number.
    always @(posedge clk) begin
        cyc_n++;
        if (wr_enable === 1'b1) begin
            wq.push_back(wr_data);
            pq.push_back(cyc_n);
        end
    end

    task automatic cyc(input logic v, input logic [7:0] b, input logic a, input logic r);
        @(negedge clk);
        in_valid = v;
        in_byte  = b;
        abort    = a;
        reset    = r;
        #1;
    endtask

    task automatic test_reset;
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready got %b exp 0", in_ready); errors++; end
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        checks++; if (wr_data !== 32'h0) begin $display("FAIL reset_wr_data got %h exp 0", wr_data); errors++; end
        checks++; if (wr_enable !== 1'b0) begin $display("FAIL reset_wr_enable got %b exp 0", wr_enable); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", busy); errors++; end
        checks++; if (words_written !== 8'd0) begin $display("FAIL reset_words got %0d exp 0", words_written); errors++; end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL reset_release busy=%b in_ready=%b exp 0/1", busy, in_ready); errors++; end
        checks++; if (wq.size() !== 0) begin $display("FAIL reset_no_write got %0d pulses exp 0", wq.size()); errors++; end
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = wq.size();
        cyc(1'b1, 8'h32, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        checks++; if (busy !== 1'b1) begin $display("FAIL b2b_busy got %b exp 1", busy); errors++; end
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (wr_enable !== 1'b1 || wr_data !== 32'd50) begin
            $display("FAIL b2b_write en=%b data=%h exp 1/00000032", wr_enable, wr_data); errors++; end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (wr_enable !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL b2b_after en=%b busy=%b exp 0/0", wr_enable, busy); errors++; end
        checks++; if (words_written !== 8'd1) begin $display("FAIL b2b_words got %0d exp 1", words_written); errors++; end
        checks++; if (wq.size() - n0 !== 1) begin $display("FAIL b2b_pulses got %0d exp 1", wq.size() - n0); errors++; end
    endtask

    task automatic test_gaps;
        int n0;
        logic [7:0] bytes [3];
        n0 = wq.size();
        bytes[0] = 8'h64; bytes[1] = 8'h00; bytes[2] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, bytes[k], 1'b0, 1'b1);
            for (int g = 0; g < 2; g++) begin
                cyc(1'b0, 8'h00, 1'b0, 1'b1);
                checks++; if (wr_data !== 32'd50 || wr_enable !== 1'b0) begin
                    $display("FAIL gap_hold byte%0d data=%h en=%b exp 00000032/0", k, wr_data, wr_enable); errors++; end
            end
        end
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (wr_enable !== 1'b1 || wr_data !== 32'd100) begin
            $display("FAIL gap_write en=%b data=%h exp 1/00000064", wr_enable, wr_data); errors++; end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (words_written !== 8'd2) begin $display("FAIL gap_words got %0d exp 2", words_written); errors++; end
        checks++; if (wq.size() - n0 !== 1) begin $display("FAIL gap_pulses got %0d exp 1", wq.size() - n0); errors++; end
    endtask

    task automatic test_abort;
        int n0;
        n0 = wq.size();
        cyc(1'b1, 8'hAA, 1'b0, 1'b1);
        cyc(1'b1, 8'hBB, 1'b0, 1'b1);
        cyc(1'b1, 8'hCC, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (busy !== 1'b0 || wr_data !== 32'd100) begin
            $display("FAIL abort_idle busy=%b data=%h exp 0/00000064", busy, wr_data); errors++; end
        cyc(1'b1, 8'h0A, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (wr_enable !== 1'b1 || wr_data !== 32'h0000000A) begin
            $display("FAIL abort_write en=%b data=%h exp 1/0000000a", wr_enable, wr_data); errors++; end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (words_written !== 8'd3) begin $display("FAIL abort_words got %0d exp 3", words_written); errors++; end
        checks++; if (wq.size() - n0 !== 1) begin $display("FAIL abort_pulses got %0d exp 1", wq.size() - n0); errors++; end
    endtask

    task automatic test_continuous;
        int n0;
        n0 = wq.size();
        cyc(1'b1, 8'h1E, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h28, 1'b0, 1'b1);
        checks++; if (in_ready !== 1'b0 || wr_enable !== 1'b1) begin
            $display("FAIL cont_stall in_ready=%b en=%b exp 0/1", in_ready, wr_enable); errors++; end
        cyc(1'b1, 8'h28, 1'b0, 1'b1);
        checks++; if (in_ready !== 1'b1) begin $display("FAIL cont_resume in_ready=%b exp 1", in_ready); errors++; end
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (in_ready !== 1'b0 || wr_enable !== 1'b1) begin
            $display("FAIL cont_write2 in_ready=%b en=%b exp 0/1", in_ready, wr_enable); errors++; end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (wq.size() - n0 !== 2) begin
            $display("FAIL cont_pulses got %0d exp 2", wq.size() - n0); errors++;
        end else begin
            checks++; if (wq[n0] !== 32'd30 || wq[n0+1] !== 32'd40) begin
                $display("FAIL cont_data got %h,%h exp 0000001e,00000028", wq[n0], wq[n0+1]); errors++; end
            checks++; if (pq[n0+1] - pq[n0] !== 5) begin
                $display("FAIL cont_spacing got %0d exp 5", pq[n0+1] - pq[n0]); errors++; end
        end
        checks++; if (words_written !== 8'd5) begin $display("FAIL cont_words got %0d exp 5", words_written); errors++; end
    endtask

    task automatic test_reset_midword;
        int n0;
        n0 = wq.size();
        cyc(1'b1, 8'h11, 1'b0, 1'b1);
        cyc(1'b1, 8'h22, 1'b0, 1'b1);
        cyc(1'b1, 8'h33, 1'b0, 1'b1);
        cyc(1'b1, 8'h44, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0) begin $display("FAIL mid_in_ready got %b exp 0", in_ready); errors++; end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (wr_data !== 32'h0 || wr_enable !== 1'b0 || busy !== 1'b0 || words_written !== 8'd0) begin
            $display("FAIL mid_outputs data=%h en=%b busy=%b words=%0d exp all 0", wr_data, wr_enable, busy, words_written);
            errors++; end
        for (int k = 0; k < 4; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (wq.size() - n0 !== 0) begin $display("FAIL mid_pulses got %0d exp 0", wq.size() - n0); errors++; end
    endtask

    task automatic test_wrap;
        int n0;
        n0 = wq.size();
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b1);
            if (i == 255) begin
                checks++; if (words_written !== 8'd255) begin
                    $display("FAIL wrap_255 got %0d exp 255", words_written); errors++; end
            end
            cyc(1'b1, 8'h00, 1'b0, 1'b1);
            cyc(1'b1, 8'h00, 1'b0, 1'b1);
            cyc(1'b1, 8'h00, 1'b0, 1'b1);
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (words_written !== 8'd0) begin $display("FAIL wrap_zero got %0d exp 0", words_written); errors++; end
        checks++; if (wr_data !== 32'd255) begin $display("FAIL wrap_data got %h exp 000000ff", wr_data); errors++; end
        checks++; if (wq.size() - n0 !== 256) begin $display("FAIL wrap_pulses got %0d exp 256", wq.size() - n0); errors++; end
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        abort    = 1'b0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_abort();
        test_continuous();
        test_reset_midword();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
